// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, four-beat burst memory port.
// One transfer at a time: the request, address and write data are captured when it leaves idle.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,

  // Cache side
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,

  // Physical memory side
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e         state_q;
  logic [1:0]     cnt_q;
  logic [31:0]    addr_q;
  logic [255:0]   wbuf_q;
  logic [255:0]   line_q;
  logic           read_q;
  logic           write_q;
  logic           resp_q;

  // Single state machine; the request strobes are registered alongside the state so they
  // change on exactly the same edges as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wbuf_q  <= 256'd0;
      line_q  <= 256'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (read_i || write_i) begin
            state_q <= read_i ? StRead : StWrite;
            read_q  <= read_i;
            write_q <= ~read_i;
            addr_q  <= {address_i[31:5], 5'b0};
            wbuf_q  <= line_i;
            cnt_q   <= 2'd0;
          end
        end

        StRead: begin
          if (resp_i) begin
            line_q[{cnt_q, 6'd0} +: 64] <= burst_i;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= StDone;
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end

        StWrite: begin
          if (resp_i) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= StDone;
              write_q <= 1'b0;
              resp_q  <= 1'b1;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
          resp_q  <= 1'b0;
        end
      endcase
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  // Outside WRITE the beat is meaningless to memory but kept deterministic.
  assign burst_o   = wbuf_q[{cnt_q, 6'd0} +: 64];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: scoreboarded read lines and write beats.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic [31:0]  address_i = '0;
  logic         read_i = 1'b0;
  logic         write_i = 1'b0;
  logic         resp_o;
  logic [63:0]  burst_i = '0;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_line_q[$];
  logic [63:0]  exp_beat_q[$];

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one four-beat read (resp_i high every beat); no comparisons here.
  task automatic run_read(input logic [31:0] addr, input logic also_write,
                          input logic [255:0] line, output logic rd, output logic wr_any,
                          output logic [31:0] adr, output int pulses, output int resp_at);
    @(negedge clk);
    address_i = addr; read_i = 1'b1; write_i = also_write; resp_i = 1'b0;
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0;
    rd = read_o; adr = address_o; wr_any = write_o; pulses = 0; resp_at = -1;
    for (int b = 0; b < 4; b++) begin
      burst_i = line[64*b +: 64];
      resp_i  = 1'b1;
      @(negedge clk);
      wr_any |= write_o;
      if (resp_o) begin pulses++; resp_at = b; end
    end
    resp_i = 1'b0;
    @(negedge clk);
    wr_any |= write_o;
    if (resp_o) pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 1'b1; resp_i = 1'b1; line_i = '1; address_i = '1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL reset_read_o got %b want 0", read_o); end
    n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL reset_write_o got %b want 0", write_o); end
    n_checks++; if (resp_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_o got %b want 0", resp_o); end
    n_checks++; if (address_o !== 32'd0) begin n_fail++; $display("FAIL reset_address_o got %h want 0", address_o); end
    n_checks++; if (burst_o !== 64'd0) begin n_fail++; $display("FAIL reset_burst_o got %h want 0", burst_o); end
    n_checks++; if (line_o !== 256'd0) begin n_fail++; $display("FAIL reset_line_o got %h want 0", line_o); end
    rst = 1'b0; read_i = 1'b0; resp_i = 1'b0; line_i = '0; address_i = '0;
    @(negedge clk);
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle read_o got %b want 0", read_o); end
  endtask

  task automatic test_read();
    logic [255:0] l;
    logic rd, wr;
    logic [31:0] adr;
    int pulses, at;
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    exp_line_q.push_back(l);
    run_read(32'h0000_1234, 1'b0, l, rd, wr, adr, pulses, at);
    n_checks++; if (rd !== 1'b1) begin n_fail++; $display("FAIL read_o_after_accept got %b want 1", rd); end
    n_checks++; if (adr !== 32'h0000_1220) begin n_fail++; $display("FAIL read_address got %h want 00001220", adr); end
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL read_write_o got %b want 0", wr); end
    n_checks++; if (at !== 3) begin n_fail++; $display("FAIL read_latency resp beat index got %0d want 3", at); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL read_pulses got %0d want 1", pulses); end
    n_checks++; if (line_o !== exp_line_q[0]) begin n_fail++; $display("FAIL read_line got %h want %h", line_o, exp_line_q[0]); end
    void'(exp_line_q.pop_front());
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL read_idle_read_o got %b want 0", read_o); end
  endtask

  task automatic test_write();
    logic [63:0] a, b, c, d, exp;
    logic [255:0] held;
    int pulses;
    a = 64'hAAAA_0000_AAAA_0001; b = 64'hBBBB_0000_BBBB_0002;
    c = 64'hCCCC_0000_CCCC_0003; d = 64'hDDDD_0000_DDDD_0004;
    held = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    @(negedge clk);
    line_i = {d, c, b, a}; address_i = 32'h8000_0040; write_i = 1'b1;
    exp_beat_q.push_back(a); exp_beat_q.push_back(b);
    exp_beat_q.push_back(c); exp_beat_q.push_back(d);
    @(negedge clk);
    write_i = 1'b0; line_i = ~line_i; address_i = 32'hFFFF_FFFF;
    n_checks++; if (write_o !== 1'b1) begin n_fail++; $display("FAIL write_o_after_accept got %b want 1", write_o); end
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL write_read_o got %b want 0", read_o); end
    n_checks++; if (address_o !== 32'h8000_0040) begin n_fail++; $display("FAIL write_address got %h want 80000040", address_o); end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      exp = exp_beat_q.pop_front();
      for (int g = 0; g < 3; g++) begin
        n_checks++;
        if (burst_o !== exp || write_o !== 1'b1) begin
          n_fail++;
          $display("FAIL write_beat%0d_gap%0d burst_o got %h want %h write_o got %b", k, g, burst_o, exp, write_o);
        end
        resp_i = (g == 2);
        @(negedge clk);
        if (resp_o) pulses++;
      end
    end
    resp_i = 1'b0;
    n_checks++; if (write_o !== 1'b0) begin n_fail++; $display("FAIL write_o_after_last got %b want 0", write_o); end
    n_checks++; if (resp_o !== 1'b1) begin n_fail++; $display("FAIL write_resp got %b want 1", resp_o); end
    n_checks++; if (line_o !== held) begin n_fail++; $display("FAIL write_line_o_held got %h want %h", line_o, held); end
    @(negedge clk);
    if (resp_o) pulses++;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL write_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_simultaneous();
    logic [255:0] l;
    logic rd, wr;
    logic [31:0] adr;
    int pulses, at;
    l = {64'h0D0D_0D0D_0000_0004, 64'h0C0C_0C0C_0000_0003,
         64'h0B0B_0B0B_0000_0002, 64'h0A0A_0A0A_0000_0001};
    exp_line_q.push_back(l);
    run_read(32'h0000_007F, 1'b1, l, rd, wr, adr, pulses, at);
    n_checks++; if (rd !== 1'b1) begin n_fail++; $display("FAIL simul_read_o got %b want 1", rd); end
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL simul_write_o_seen got %b want 0", wr); end
    n_checks++; if (adr !== 32'h0000_0060) begin n_fail++; $display("FAIL simul_address got %h want 00000060", adr); end
    n_checks++; if (line_o !== exp_line_q[0]) begin n_fail++; $display("FAIL simul_line got %h want %h", line_o, exp_line_q[0]); end
    void'(exp_line_q.pop_front());
  endtask

  task automatic test_reset_abort();
    logic [255:0] l;
    logic rd, wr;
    logic [31:0] adr;
    int pulses, at;
    @(negedge clk);
    address_i = 32'h0000_0100; read_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    pulses = 0;
    for (int b = 0; b < 2; b++) begin
      burst_i = 64'hFACE_0000_0000_0000 | 64'(b); resp_i = 1'b1;
      @(negedge clk);
      if (resp_o) pulses++;
    end
    rst = 1'b1; resp_i = 1'b0;
    @(negedge clk);
    n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL abort_read_o got %b want 0", read_o); end
    n_checks++; if (line_o !== 256'd0) begin n_fail++; $display("FAIL abort_line_o got %h want 0", line_o); end
    n_checks++; if (address_o !== 32'd0) begin n_fail++; $display("FAIL abort_address got %h want 0", address_o); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_o) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_pulses got %0d want 0", pulses); end
    l = {64'h5EED_0000_0000_0004, 64'h5EED_0000_0000_0003,
         64'h5EED_0000_0000_0002, 64'h5EED_0000_0000_0001};
    exp_line_q.push_back(l);
    run_read(32'h0000_0100, 1'b0, l, rd, wr, adr, pulses, at);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL abort_reread_pulses got %0d want 1", pulses); end
    n_checks++; if (line_o !== exp_line_q[0]) begin n_fail++; $display("FAIL abort_reread_line got %h want %h", line_o, exp_line_q[0]); end
    void'(exp_line_q.pop_front());
  endtask

  task automatic test_spurious();
    logic [255:0] held, l;
    int pulses;
    held = line_o == line_o ? {64'h5EED_0000_0000_0004, 64'h5EED_0000_0000_0003,
                               64'h5EED_0000_0000_0002, 64'h5EED_0000_0000_0001} : '0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end
    @(negedge clk);
    if (resp_o) pulses++;
    n_checks++; if (line_o !== held) begin n_fail++; $display("FAIL spurious_idle_line got %h want %h", line_o, held); end
    n_checks++; if (read_o !== 1'b0 || write_o !== 1'b0) begin n_fail++; $display("FAIL spurious_idle_req got r%b w%b want r0 w0", read_o, write_o); end
    l = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
         64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    exp_line_q.push_back(l);
    read_i = 1'b1; address_i = 32'h0000_0200; resp_i = 1'b1;
    @(negedge clk);
    read_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      burst_i = l[64*b +: 64];
      @(negedge clk);
      if (resp_o) pulses++;
    end
    // resp_i stays high with junk data through DONE and the following idle cycles
    for (int i = 0; i < 3; i++) begin
      burst_i = 64'hBAD0_BAD0_BAD0_0000 | 64'(i);
      @(negedge clk);
      if (resp_o) pulses++;
    end
    resp_i = 1'b0;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL spurious_pulses got %0d want 1", pulses); end
    n_checks++; if (line_o !== exp_line_q[0]) begin n_fail++; $display("FAIL spurious_line got %h want %h", line_o, exp_line_q[0]); end
    void'(exp_line_q.pop_front());
  endtask

  task automatic test_back_to_back();
    logic [63:0] bk[11];
    int resp_k[$];
    int gap;
    for (int k = 0; k < 11; k++) bk[k] = {32'hB2B0_0000 + 32'(k), 32'h0F0F_0000 + 32'(k)};
    exp_line_q.push_back({bk[4], bk[3], bk[2], bk[1]});
    exp_line_q.push_back({bk[10], bk[9], bk[8], bk[7]});
    address_i = 32'h0000_0400;
    for (int k = 0; k < 11; k++) begin
      read_i = 1'b1; resp_i = 1'b1; burst_i = bk[k];
      @(negedge clk);
      if (resp_o) begin
        resp_k.push_back(k);
        n_checks++;
        if (exp_line_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_resp at k=%0d got pulse want none", k);
        end else begin
          if (line_o !== exp_line_q[0]) begin
            n_fail++; $display("FAIL b2b_line k=%0d got %h want %h", k, line_o, exp_line_q[0]);
          end
          void'(exp_line_q.pop_front());
        end
      end
      if (k == 5) begin
        n_checks++; if (read_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap read_o got %b want 0", read_o); end
      end
    end
    read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp_k.size() !== 2) begin
      n_fail++; $display("FAIL b2b_pulse_count got %0d want 2", resp_k.size());
    end else begin
      gap = resp_k[1] - resp_k[0];
      if (gap < 5) begin n_fail++; $display("FAIL b2b_pulse_gap got %0d want >=5", gap); end
    end
    n_checks++; if (exp_line_q.size() !== 0) begin n_fail++; $display("FAIL b2b_lines_left got %0d want 0", exp_line_q.size()); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_reset_abort();
    test_spurious();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have the following ports, clock and reset first:
- clk  input  1  single clock for all state
- rst  input  1  synchronous, active-high reset
- line_i  input  256  cache line to write to pmem
- line_o  output  256  cache line assembled from pmem read
- address_i  input  32  cache-side byte address
- read_i  input  1  cache-side line read request
- write_i  input  1  cache-side line write request
- resp_o  output  1  line transfer complete (1-cycle pulse)
- burst_i  input  64  pmem read beat
- burst_o  output  64  pmem write beat
- address_o  output  32  pmem address
- read_o  output  1  pmem read request
- write_o  output  1  pmem write request
- resp_i  input  1  pmem beat accepted/valid
REQ-002 SHALL be a single-clock design: one clock (clk), synchronous active-high reset (rst); no other clocks or async resets.

Function
REQ-003 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-004 IDLE: read_i=1 -> READ at next edge; else write_i=1 -> WRITE; read_i and write_i both 1 -> read wins.
REQ-005 On leaving IDLE, SHALL latch {address_i[31:5],5'b0} into the address register and line_i into the write buffer; beat counter cleared to 0.
REQ-006 address_o SHALL always drive the latched, 32-byte-aligned address; low 5 bits always 0.
REQ-007 read_o=1 exactly while in READ; write_o=1 exactly while in WRITE; both 0 in IDLE and DONE.
REQ-008 READ: each cycle with resp_i=1 SHALL store burst_i into line_o[64*cnt +: 64] and increment cnt (2-bit); beat 0 = bits 63:0.
REQ-009 WRITE: burst_o SHALL equal write_buffer[64*cnt +: 64]; each cycle with resp_i=1 increments cnt.
REQ-010 resp_i=1 with cnt=3 in READ/WRITE -> DONE at next edge; cnt wraps to 0.
REQ-011 resp_i=0 in READ/WRITE -> hold state, cnt, outputs; no timeout.
REQ-012 DONE: resp_o=1 for exactly one cycle, then IDLE unconditionally; requests in DONE cycle ignored.
REQ-013 resp_o=0 in all states except DONE.
REQ-014 resp_i in IDLE or DONE SHALL be ignored (no state, cnt, or line_o change).
REQ-015 line_o SHALL hold the last completed read line until the next read beats overwrite it; a write SHALL not modify line_o.
REQ-016 Changes to line_i/address_i after request acceptance SHALL not affect the transfer in progress.
REQ-017 Minimum latency: request seen in IDLE at edge N -> read_o/write_o high cycle N+1; with resp_i held high, resp_o high cycle N+5.
REQ-018 burst_o in states other than WRITE SHALL be the write_buffer beat selected by cnt (don't-care for pmem, but deterministic).

Reset
REQ-019 rst=1 at clk edge SHALL force IDLE, cnt=0, address register=0, write buffer=0, line_o=0, from any state.
REQ-020 During/after reset: read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0.
REQ-021 Reset mid-READ/WRITE SHALL abort the transfer; no resp_o pulse for the aborted request.

Verification
REQ-022 Read: address_i=0x0000_1234, read_i=1; resp_i high 4 cycles with burst_i=0x11..11,0x22..22,0x33..33,0x44..44 -> address_o=0x0000_1220, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, one resp_o pulse 5 cycles after acceptance.
REQ-023 Write: line_i=256'h{D,C,B,A} (64-bit beats), address_i=0x8000_0040, write_i=1; resp_i with 2-cycle gaps -> burst_o=A,B,C,D in order, each held until its resp_i, write_o low after 4th beat, single resp_o.
REQ-024 Simultaneous read_i=1, write_i=1 in IDLE -> READ entered, write_o never asserted for that request.
REQ-025 Reset asserted after 2 read beats -> next cycle IDLE, read_o=0, resp_o never pulses, line_o=0; new read then completes normally.
REQ-026 Spurious resp_i=1 while IDLE and DONE -> no state change, line_o unchanged, resp_o only the single DONE pulse.
REQ-027 Back-to-back: read_i held through DONE -> IDLE one cycle, new READ starts following cycle; resp_o pulses twice, separated by ≥5 cycles.
